// File: rtl/aes_inv_core.sv
// aes_inv_core: iterative AES-128 inverse cipher. It runs one round per cycle and fetches round keys by key_idx.
// The optional abort input is enabled by defining AES_INV_CORE_ABORT_EN.

module aes_inv_mixcol (
    input  logic [31:0] col_in,
    output logic [31:0] col_out
);
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    logic [3:0][7:0] a, x2, x4, x8;

    // 0e = x8^x4^x2, 0b = x8^x2^x, 0d = x8^x4^x, 09 = x8^x
    for (genvar r = 0; r < 4; r++) begin : g_row
        assign a[r]  = col_in[31-8*r -: 8];
        assign x2[r] = xt(a[r]);
        assign x4[r] = xt(x2[r]);
        assign x8[r] = xt(x4[r]);
        assign col_out[31-8*r -: 8] = (x8[r] ^ x4[r] ^ x2[r])
                                    ^ (x8[(r+1)%4] ^ x2[(r+1)%4] ^ a[(r+1)%4])
                                    ^ (x8[(r+2)%4] ^ x4[(r+2)%4] ^ a[(r+2)%4])
                                    ^ (x8[(r+3)%4] ^ a[(r+3)%4]);
    end
endmodule

module aes_inv_core (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] ciphertext,
    output logic [3:0]   key_idx,
    input  logic [127:0] round_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] plaintext,
`ifdef AES_INV_CORE_ABORT_EN
    input  logic         abort,
`endif
    output logic         busy
);
    typedef enum logic [1:0] {IDLE = 2'd0, ROUND = 2'd1, DONE = 2'd2} st_t;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, m;
        p = 8'h00;
        x = a;
        m = b;
        for (int i = 0; i < 8; i++) begin
            if (m[0]) p = p ^ x;
            x = xt(x);
            m = m >> 1;
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse and naturally maps 0 to 0
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] s, r;
        s = a;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            s = gmul(s, s);
            r = gmul(r, s);
        end
        return r;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] a;
        a = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
        return ginv(a);
    endfunction

    st_t          st;
    logic [3:0]   rnd;
    logic [127:0] state, sr_sb, add_key, mixed;

    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_byte
            assign sr_sb[127-8*(4*c+r) -: 8] = inv_sbox(state[127-8*(4*((c-r+4)%4)+r) -: 8]);
        end
        aes_inv_mixcol u_mix (
            .col_in  (add_key[127-32*c -: 32]),
            .col_out (mixed[127-32*c -: 32])
        );
    end

    assign add_key  = sr_sb ^ round_key;
    assign in_ready = (st == IDLE);
    assign busy     = (st != IDLE);

    // key_idx is a registered output that is kept one step ahead, so the store's key matches rnd
    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= IDLE;
            rnd       <= 4'd0;
            state     <= '0;
            plaintext <= '0;
            out_valid <= 1'b0;
            key_idx   <= 4'd10;
        end
`ifdef AES_INV_CORE_ABORT_EN
        else if (abort && st != IDLE) begin
            st        <= IDLE;
            rnd       <= 4'd0;
            out_valid <= 1'b0;
            key_idx   <= 4'd10;
        end
`endif
        else begin
            case (st)
                IDLE: begin
                    if (in_valid) begin
                        state   <= ciphertext ^ round_key;
                        rnd     <= 4'd9;
                        key_idx <= 4'd9;
                        st      <= ROUND;
                    end
                end
                ROUND: begin
                    if (rnd == 4'd0) begin
                        plaintext <= add_key;
                        out_valid <= 1'b1;
                        key_idx   <= 4'd10;
                        st        <= DONE;
                    end else begin
                        state   <= mixed;
                        rnd     <= rnd - 4'd1;
                        key_idx <= rnd - 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        st        <= IDLE;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_inv_core.sv
// Bench for aes_inv_core: it models the key store with FIPS-197 key expansion and checks the output against known vectors and a forward-cipher model.
module tb_aes_inv_core;
    localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT2 = 128'h3243f6a8885a308d313198a2e0370734;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, out_valid, out_ready, busy;
    logic [127:0] ciphertext, round_key, plaintext;
    logic [3:0]   key_idx;
`ifdef AES_INV_CORE_ABORT_EN
    logic         abort;
`endif
    int           checks = 0;
    int           failures = 0;
    logic [7:0]   sbox [256];
    logic [127:0] rk [2][11];
    logic         kset;

    always #5 clk = ~clk;

    assign round_key = (key_idx <= 4'd10) ? rk[kset][key_idx] : '0;

    aes_inv_core dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ciphertext (ciphertext),
        .key_idx    (key_idx),
        .round_key  (round_key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .plaintext  (plaintext),
`ifdef AES_INV_CORE_ABORT_EN
        .abort      (abort),
`endif
        .busy       (busy)
    );

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, m;
        p = 0; x = a; m = b;
        repeat (8) begin
            if (m[0]) p = p ^ x;
            x = xt(x);
            m = m >> 1;
        end
        return p;
    endfunction

    // Forward S-box: brute-force inverse, then the affine map
    function automatic void build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] a;
            a = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gm(8'(x), 8'(y)) == 8'h01) a = 8'(y);
            sbox[x] = a ^ {a[6:0], a[7]} ^ {a[5:0], a[7:6]} ^ {a[4:0], a[7:5]} ^ {a[3:0], a[7:4]} ^ 8'h63;
        end
    endfunction

    function automatic void expand_key(input int slot, input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[slot][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    function automatic logic [127:0] encrypt(input int slot, input logic [127:0] pt);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] res;
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk[slot][0][127-8*i -: 8];
        for (int rd = 1; rd <= 10; rd++) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) t[4*c+r] = sbox[s[4*((c+r)%4)+r]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    s[4*c+r] = (rd == 10) ? t[4*c+r] :
                               gm(8'h02, t[4*c+r]) ^ gm(8'h03, t[4*c+(r+1)%4]) ^ t[4*c+(r+2)%4] ^ t[4*c+(r+3)%4];
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[slot][rd][127-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    task automatic send(input logic [127:0] ct);
        @(negedge clk); ciphertext = ct; in_valid = 1'b1;
        @(negedge clk); in_valid = 1'b0;
    endtask

    // n counts edges from the accept edge (n=1 right after it); -1 on timeout
    task automatic wait_out(input int start, output int n);
        n = start;
        while (!out_valid && n < 40) begin @(negedge clk); n++; end
        if (!out_valid) n = -1;
    endtask

    task automatic handshake();
        out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; ciphertext = CT1;
        repeat (3) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (plaintext !== '0) begin failures++; $display("FAIL reset_plaintext: got %h want 0", plaintext); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (key_idx !== 4'd10) begin failures++; $display("FAIL reset_key_idx: got %0d want 10", key_idx); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle_after: got busy=%b want 0", busy); end
    endtask

    task automatic test_vector1();
        int bad_n;
        kset = 1'b0;
        @(negedge clk); ciphertext = CT1; in_valid = 1'b1;
        checks++; if (key_idx !== 4'd10) begin failures++; $display("FAIL v1_idle_key_idx: got %0d want 10", key_idx); end
        @(negedge clk); in_valid = 1'b0;
        bad_n = 0;
        for (int n = 1; n <= 10; n++) begin
            if ((key_idx !== 4'(10 - n) || out_valid !== 1'b0) && bad_n == 0) bad_n = n;
            @(negedge clk);
        end
        checks++; if (bad_n != 0) begin failures++; $display("FAIL v1_key_seq: first bad step %0d want 0", bad_n); end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL v1_latency: out_valid=%b at edge E+10 want 1", out_valid); end
        checks++; if (plaintext !== PT1) begin failures++; $display("FAIL v1_plaintext: got %h want %h", plaintext, PT1); end
        checks++; if (key_idx !== 4'd10) begin failures++; $display("FAIL v1_done_key_idx: got %0d want 10", key_idx); end
        handshake();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL v1_handshake: got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready); end
    endtask

    task automatic test_stall();
        int n;
        logic ok;
        kset = 1'b1;
        send(CT2);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready_round: got %b want 0", in_ready); end
        wait_out(1, n);
        checks++; if (n != 11) begin failures++; $display("FAIL stall_latency: got %0d want 11", n); end
        ok = 1'b1;
        repeat (5) begin
            if (plaintext !== PT2 || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) ok = 1'b0;
            @(negedge clk);
        end
        checks++; if (!ok || plaintext !== PT2) begin failures++; $display("FAIL stall_hold: got %h want %h held", plaintext, PT2); end
        handshake();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stall_release: got out_valid=%b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        int t1, t2;
        logic [127:0] p1, p2;
        t1 = -1; t2 = -1; p1 = '0; p2 = '0;
        @(negedge clk); kset = 1'b0; ciphertext = CT1; in_valid = 1'b1; out_ready = 1'b1;
        for (int n = 1; n <= 40 && t2 < 0; n++) begin
            @(negedge clk);
            if (out_valid) begin
                if (t1 < 0) begin t1 = n; p1 = plaintext; kset = 1'b1; ciphertext = CT2; end
                else begin t2 = n; p2 = plaintext; in_valid = 1'b0; end
            end
        end
        in_valid = 1'b0;
        @(negedge clk); out_ready = 1'b0;
        checks++; if (t1 != 11) begin failures++; $display("FAIL b2b_t1: got %0d want 11", t1); end
        checks++; if (p1 !== PT1) begin failures++; $display("FAIL b2b_pt1: got %h want %h", p1, PT1); end
        checks++; if (t2 != 23) begin failures++; $display("FAIL b2b_t2: got %0d want 23", t2); end
        checks++; if (p2 !== PT2) begin failures++; $display("FAIL b2b_pt2: got %h want %h", p2, PT2); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_idle: got busy=%b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        int n;
        logic ok;
        kset = 1'b0;
        send(CT1);
        repeat (4) @(negedge clk);
        checks++; if (key_idx !== 4'd5) begin failures++; $display("FAIL rmid_key_idx: got %0d want 5", key_idx); end
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL rmid_idle: got busy=%b in_ready=%b want 0 1", busy, in_ready); end
        checks++; if (out_valid !== 1'b0 || plaintext !== '0) begin failures++; $display("FAIL rmid_out: got %b %h want 0 0", out_valid, plaintext); end
        checks++; if (key_idx !== 4'd10) begin failures++; $display("FAIL rmid_key10: got %0d want 10", key_idx); end
        ok = 1'b1;
        repeat (15) begin @(negedge clk); if (out_valid !== 1'b0 || busy !== 1'b0) ok = 1'b0; end
        checks++; if (!ok) begin failures++; $display("FAIL rmid_no_output: got activity want none"); end
        send(CT1);
        wait_out(1, n);
        checks++; if (n != 11 || plaintext !== PT1) begin failures++; $display("FAIL rmid_redo: got n=%0d pt=%h want 11 %h", n, plaintext, PT1); end
        handshake();
    endtask

    task automatic test_busy_ignore();
        int n;
        kset = 1'b1;
        send(CT2);
        @(negedge clk); ciphertext = {$urandom, $urandom, $urandom, $urandom}; in_valid = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        wait_out(3, n);
        checks++; if (n != 11) begin failures++; $display("FAIL busy_latency: got %0d want 11", n); end
        checks++; if (plaintext !== PT2) begin failures++; $display("FAIL busy_pt: got %h want %h", plaintext, PT2); end
        ciphertext = {$urandom, $urandom, $urandom, $urandom}; in_valid = 1'b1;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        checks++; if (plaintext !== PT2 || out_valid !== 1'b1) begin failures++; $display("FAIL busy_done_hold: got %b %h want 1 %h", out_valid, plaintext, PT2); end
        handshake();
        @(negedge clk);
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL busy_after: got busy=%b out_valid=%b want 0 0", busy, out_valid); end
    endtask

    task automatic test_random();
        int n;
        logic [127:0] key, pt, ct;
        kset = 1'b0;
        for (int it = 0; it < 20; it++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            pt  = {$urandom, $urandom, $urandom, $urandom};
            expand_key(0, key);
            ct = encrypt(0, pt);
            send(ct);
            wait_out(1, n);
            checks++; if (n != 11) begin failures++; $display("FAIL rand_latency[%0d]: got %0d want 11", it, n); end
            checks++; if (plaintext !== pt) begin failures++; $display("FAIL rand_pt[%0d]: got %h want %h", it, plaintext, pt); end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            handshake();
        end
        expand_key(0, K1);
    endtask

`ifdef AES_INV_CORE_ABORT_EN
    task automatic test_abort();
        int n;
        logic ok;
        logic [127:0] prev;
        kset = 1'b0;
        prev = plaintext;
        send(CT1);
        repeat (6) @(negedge clk);
        checks++; if (key_idx !== 4'd3) begin failures++; $display("FAIL abort_key_idx: got %0d want 3", key_idx); end
        abort = 1'b1; @(negedge clk); abort = 1'b0;
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL abort_round: got busy=%b out_valid=%b want 0 0", busy, out_valid); end
        checks++; if (plaintext !== prev) begin failures++; $display("FAIL abort_pt_keep: got %h want %h", plaintext, prev); end
        ok = 1'b1;
        repeat (15) begin @(negedge clk); if (out_valid !== 1'b0) ok = 1'b0; end
        checks++; if (!ok) begin failures++; $display("FAIL abort_no_output: got out_valid want none"); end
        @(negedge clk); abort = 1'b1; ciphertext = CT1; in_valid = 1'b1;
        @(negedge clk); abort = 1'b0; in_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL abort_idle_ignored: got busy=%b want 1", busy); end
        wait_out(1, n);
        checks++; if (n != 11 || plaintext !== PT1) begin failures++; $display("FAIL abort_redo: got n=%0d pt=%h want 11 %h", n, plaintext, PT1); end
        abort = 1'b1; out_ready = 1'b1;
        @(negedge clk); abort = 1'b0; out_ready = 1'b0;
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || plaintext !== PT1) begin failures++; $display("FAIL abort_done: got busy=%b ov=%b pt=%h want 0 0 %h", busy, out_valid, plaintext, PT1); end
    endtask
`endif

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; ciphertext = '0; kset = 1'b0;
`ifdef AES_INV_CORE_ABORT_EN
        abort = 1'b0;
`endif
        build_sbox();
        expand_key(0, K1);
        expand_key(1, K2);
        test_reset();
        test_vector1();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_busy_ignore();
        test_random();
`ifdef AES_INV_CORE_ABORT_EN
        test_abort();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/aes_inv_core.md
AES_INV_CORE -- requirements
Module: aes_inv_core

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 in_valid  in  1  ciphertext offered.
REQ-005 in_ready  out  1  block can accept ciphertext.
REQ-006 ciphertext  in  128  input block; byte 0 = bits [127:120]; state[r][c] = byte 4c+r (FIPS-197 order).
REQ-007 key_idx  out  4  index (0..10) of the round key requested from the external key store.
REQ-008 round_key  in  128  expanded key for key_idx, valid in the same cycle; same byte order as ciphertext.
REQ-009 out_valid  out  1  plaintext available.
REQ-010 out_ready  in  1  consumer accepts plaintext.
REQ-011 plaintext  out  128  registered result; same byte order as ciphertext.
REQ-012 busy  out  1  high in ROUND or DONE.

Function
REQ-013 The FSM SHALL have three states: IDLE, ROUND and DONE.
REQ-014 IDLE: in_ready=1; key_idx=10; in_valid&&in_ready at edge E loads state <= ciphertext ^ K10 and sets rnd=9; next state is ROUND.
REQ-015 ROUND, rnd 9..1: key_idx=rnd; each edge updates state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ K[rnd]) and decrements rnd.
REQ-016 ROUND, rnd=0: key_idx=0; the edge writes plaintext <= InvSubBytes(InvShiftRows(state)) ^ K0, sets out_valid=1 and moves to DONE.
REQ-017 Latency: an accept at edge E SHALL make out_valid high after edge E+10; the block accepts at most one block per 11 cycles.
REQ-018 DONE: in_ready=0; key_idx=10; plaintext and out_valid stay stable until out_valid&&out_ready.
REQ-019 The output handshake edge SHALL clear out_valid and return the FSM to IDLE.
REQ-020 in_valid in ROUND or DONE SHALL be ignored (no state change); ciphertext is sampled only at the accept edge.
REQ-021 InvSubBytes SHALL be combinational: inverse affine transform followed by the GF(2^8) inverse (poly 0x11B), with 0x00 mapping to 0x00; a 256-entry table is permitted instead.
REQ-022 InvShiftRows SHALL rotate row r right by r bytes.
REQ-023 InvMixColumns SHALL use the coefficients {0e,0b,0d,09} with xtime-based GF(2^8) multiplication.
REQ-024 All 4 columns SHALL be processed in parallel, giving one round per cycle.

Reset
REQ-025 rst SHALL set: FSM to IDLE, rnd=0, state=0, plaintext=0, out_valid=0, busy=0, in_ready=1 (combinational from IDLE) and key_idx=10.
REQ-026 rst in any state, including mid-ROUND, SHALL discard the block in flight and produce no output; rst has priority over both handshakes.

Configuration
REQ-027 Macro AES_INV_CORE_ABORT_EN defined: an input port abort (1 bit) exists.
REQ-028 With the macro, abort=1 in ROUND or DONE SHALL force IDLE on the next edge, clear out_valid and leave plaintext unchanged.
REQ-029 With the macro, abort SHALL be ignored in IDLE.
REQ-030 With the macro, rst SHALL take priority over abort, and abort SHALL take priority over the output handshake.
REQ-031 Macro undefined: the abort port and its logic SHALL be absent and all other behaviour is identical.

Verification (bench models the key store from the FIPS-197 key expansion)
REQ-032 Key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a -> pt 00112233445566778899aabbccddeeff, out_valid exactly 10 edges after accept; key_idx sequence 10,9,...,0.
REQ-033 Key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32, out_ready held low 5 cycles -> pt 3243f6a8885a308d313198a2e0370734 held stable; in_ready=0 throughout.
REQ-034 Both vectors back-to-back with in_valid held high and out_ready=1 -> two correct outputs; second accept on the edge after the first output handshake.
REQ-035 rst asserted when rnd=5 -> next cycle IDLE, out_valid=0, plaintext=0; a following REQ-032 vector decrypts correctly.
REQ-036 in_valid pulsed with a random ct while busy -> ignored; the original pt is unchanged.
REQ-037 (AES_INV_CORE_ABORT_EN) abort at rnd=3 -> IDLE next edge with no out_valid; abort asserted together with out_ready in DONE -> IDLE, with no handshake counted.
